bcd_to_bin_seq: RTL and testbench

//  Sequential packed-BCD to unsigned binary converter for the BCD2Bin datapath.

---
 rtl/bcd_to_bin_seq.sv | 103 ++++++++++
 tb/tb_bcd_to_bin_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter.
// Reverse double-dabble, one bit per clock.
module bcd_to_bin_seq #(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BIN_W-1:0]       bin_out
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state;
  logic [2*W-1:0] sreg;
  logic [2*W-1:0] shifted;
  logic [2*W-1:0] corr;
  logic [CW-1:0]  cnt;
  logic           bad;

  // Flag any input digit above 9
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One shift step: move right, then pull each digit >= 8 down by 3
  always_comb begin
    shifted = sreg >> 1;
    corr    = shifted;
    for (int i = 0; i < NDIGITS; i++) begin
      if (shifted[W+4*i +: 4] >= 4'd8) begin
        corr[W+4*i +: 4] = shifted[W+4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered status and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (bad) begin
              state   <= S_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              bin_out <= '0;
            end else begin
              sreg  <= {bcd_in, {W{1'b0}}};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          sreg <= corr;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            bin_out <= corr[BIN_W-1:0];
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq.
// Hand-computed vectors, inline checks.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] bin_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(
    .NDIGITS(4),
    .BIN_W  (14)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bin_out(bin_out)
  );

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap busy=%b done=%b want not both",
                 busy, done);
      end
    end
  end

  task automatic accept(input logic [15:0] b);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 16'hFFFF;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, err, bin_out});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h want=0",
               {busy, done, err, bin_out});
    end
  endtask

  task automatic test_convert(input logic [15:0] b,
                              input logic [13:0] exp);
    int lat;
    int bc;
    accept(b);
    wait_done(lat, bc);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL latency_%h got=%0d want=16", b, lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++;
      $display("FAIL busy_len_%h got=%0d want=16", b, bc);
    end
    checks++;
    if (bin_out !== exp || err !== 1'b0) begin
      errors++;
      $display("FAIL result_%h got=%0d err=%b want=%0d err=0",
               b, bin_out, err, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bin_out !== exp) begin
      errors++;
      $display("FAIL after_done_%h done=%b busy=%b bin=%0d want 0 0 %0d",
               b, done, busy, bin_out, exp);
    end
  endtask

  task automatic test_invalid(input logic [15:0] b);
    accept(b);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL inv_done_%h done=%b busy=%b want 1 0", b, done, busy);
    end
    checks++;
    if (err !== 1'b1 || bin_out !== 14'd0) begin
      errors++;
      $display("FAIL inv_result_%h err=%b bin=%0d want 1 0",
               b, err, bin_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL inv_after_%h done=%b busy=%b err=%b want 0 0 1",
               b, done, busy, err);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int bc;
    accept(16'h0500);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || err !== 1'b1 || bin_out !== 14'd0) begin
      errors++;
      $display("FAIL hold_in_shift busy=%b err=%b bin=%0d want 1 1 0",
               busy, err, bin_out);
    end
    start  = 1'b1;
    bcd_in = 16'h9999;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    wait_done(lat, bc);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL ignore_latency got=%0d want=11", lat);
    end
    checks++;
    if (bin_out !== 14'd500 || err !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got=%0d err=%b want=500 err=0",
               bin_out, err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL no_queue busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h1234;
    @(posedge clk);
    #1;
    bcd_in = 16'h0010;
    wait_done(lat, bc);
    checks++;
    if (lat !== 16 || bin_out !== 14'h04D2) begin
      errors++;
      $display("FAIL b2b_first lat=%0d bin=%h want 16 04d2", lat, bin_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept busy=%b want 1", busy);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 16 || bin_out !== 14'd10) begin
      errors++;
      $display("FAIL b2b_second lat=%0d bin=%0d want 16 10", lat, bin_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    accept(16'h4321);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0",
               {busy, done, err, bin_out});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || bin_out !== 14'd0) begin
      errors++;
      $display("FAIL reset_hold done=%b bin=%0d want 0 0", done, bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
    test_convert(16'h0042, 14'd42);
  endtask

  initial begin
    test_reset();
    test_convert(16'h9999, 14'h270F);
    test_convert(16'h0000, 14'd0);
    test_convert(16'h1234, 14'h04D2);
    test_convert(16'h0010, 14'd10);
    test_convert(16'h0001, 14'd1);
    test_convert(16'h8080, 14'd8080);
    test_invalid(16'h12A4);
    test_invalid(16'hF000);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
